load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/lsu_align.sv | 41 ++++
 rtl/load_store_unit.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the load/store unit: access-size encodings, FSM states
// and the lane-mask base used by the alignment logic.
package riscv_pkg;

    localparam logic [1:0] LS_BYTE = 2'd0;
    localparam logic [1:0] LS_HALF = 2'd1;
    localparam logic [1:0] LS_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    // Code 2'b11 falls into the default arm and behaves as a word.
    function automatic logic [7:0] lane_base(input logic [1:0] ls_type);
        case (ls_type)
            LS_BYTE: lane_base = 8'h01;
            LS_HALF: lane_base = 8'h03;
            default: lane_base = 8'h0F;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational alignment for the load/store unit: 8-lane mask, split
// detection, store-data lane shift and load-data shift/extend.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  ls_type,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] beat0,
    input  logic [31:0] beat1,
    output logic [7:0]  lane_mask,
    output logic        split,
    output logic [31:0] wdata_lo,
    output logic [31:0] wdata_hi,
    output logic [31:0] rdata
);

    logic [4:0]  shamt;
    logic [63:0] wide_w;
    logic [31:0] rd_win;

    always_comb begin
        shamt     = {offset, 3'b000};
        lane_mask = lane_base(ls_type) << offset;
        split     = |lane_mask[7:4];
        wide_w    = {32'b0, wdata} << shamt;
        wdata_lo  = wide_w[31:0];
        wdata_hi  = wide_w[63:32];
        // Only the low word of the shifted pair can hold the loaded bytes.
        rd_win    = 32'({beat1, beat0} >> shamt);
        case (ls_type)
            LS_BYTE: rdata = is_unsigned ? {24'b0, rd_win[7:0]}
                                         : {{24{rd_win[7]}}, rd_win[7:0]};
            LS_HALF: rdata = is_unsigned ? {16'b0, rd_win[15:0]}
                                         : {{16{rd_win[15]}}, rd_win[15:0]};
            default: rdata = rd_win;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses at any alignment. With
// MISALIGNED_SPLIT_EN defined, word-crossing accesses take two beats;
// otherwise they complete at once with resp_err set and no memory strobes.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            load_store_type,
    input  logic                  load_unsigned,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [3:0]            mem_byte_en,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    // state | meaning
    // IDLE  | ready for a request; resp_valid of the previous one may pulse
    // BEAT0 | first (or only) word strobe on the memory port
    // BEAT1 | second word strobe of a split access; beat-0 read data arrives
    // RESP  | last read data arrives; response registered at end of cycle

    lsu_state_e            state;
    logic                  write_q;
    logic                  unsigned_q;
    logic                  split_q;
    logic                  err_q;
    logic [1:0]            type_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           beat0_q;

    logic                  accept;
    logic                  reject;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [1:0]            cur_type;
    logic                  cur_unsigned;
    logic [31:0]           cur_wdata;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [31:0]           beat0_sel;
    logic [31:0]           beat1_sel;
    logic [7:0]            lane_mask;
    logic                  split;
    logic [31:0]           wdata_lo;
    logic [31:0]           wdata_hi;
    logic [31:0]           load_data;

    assign accept = (state == IDLE) && req_ready && req_valid;

`ifdef MISALIGNED_SPLIT_EN
    assign reject = 1'b0;
`else
    assign reject = split;
`endif

    // The aligner sees the live request while idle and the latched one after.
    always_comb begin
        cur_addr     = (state == IDLE) ? req_addr        : addr_q;
        cur_type     = (state == IDLE) ? load_store_type : type_q;
        cur_unsigned = (state == IDLE) ? load_unsigned   : unsigned_q;
        cur_wdata    = (state == IDLE) ? req_wdata       : wdata_q;
        word_addr    = {cur_addr[ADDR_WIDTH-1:2], 2'b00};
        beat0_sel    = split_q ? beat0_q : mem_read_data;
        beat1_sel    = split_q ? mem_read_data : 32'd0;
    end

    lsu_align u_align (
        .offset      (cur_addr[1:0]),
        .ls_type     (cur_type),
        .is_unsigned (cur_unsigned),
        .wdata       (cur_wdata),
        .beat0       (beat0_sel),
        .beat1       (beat1_sel),
        .lane_mask   (lane_mask),
        .split       (split),
        .wdata_lo    (wdata_lo),
        .wdata_hi    (wdata_hi),
        .rdata       (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            req_ready      <= 1'b0;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            resp_err       <= 1'b0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_byte_en    <= 4'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            write_q        <= 1'b0;
            unsigned_q     <= 1'b0;
            split_q        <= 1'b0;
            err_q          <= 1'b0;
            type_q         <= LS_BYTE;
            addr_q         <= '0;
            wdata_q        <= '0;
            beat0_q        <= '0;
        end else begin
            resp_valid     <= 1'b0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_byte_en    <= 4'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready  <= 1'b0;
                        write_q    <= req_write;
                        unsigned_q <= load_unsigned;
                        type_q     <= load_store_type;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        split_q    <= split;
                        err_q      <= reject;
                        if (reject) begin
                            state <= RESP;
                        end else begin
                            state          <= BEAT0;
                            mem_addr       <= word_addr;
                            mem_byte_en    <= lane_mask[3:0];
                            mem_write_data <= wdata_lo;
                            mem_read       <= !req_write;
                            mem_write      <= req_write;
                        end
                    end
                end
                BEAT0: begin
                    if (split_q) begin
                        state          <= BEAT1;
                        mem_addr       <= word_addr + ADDR_WIDTH'(4);
                        mem_byte_en    <= lane_mask[7:4];
                        mem_write_data <= wdata_hi;
                        mem_read       <= !write_q;
                        mem_write      <= write_q;
                    end else begin
                        state <= RESP;
                    end
                end
                BEAT1: begin
                    beat0_q <= mem_read_data;
                    state   <= RESP;
                end
                RESP: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b1;
                    resp_err   <= err_q;
                    resp_rdata <= (write_q || err_q) ? 32'd0 : load_data;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
